// File: rtl/servo_hall_pkg.sv
// Shared definitions for the Hall-sensor decoder: sector width, fault bit
// positions and the Hall-code / sector arithmetic helpers.
package servo_hall_pkg;

  localparam int SECTOR_W      = 3;
  localparam int FAULT_INVALID = 0;
  localparam int FAULT_SKIP    = 1;

  // Returns {valid, sector}; 000 and 111 are the two impossible Hall codes.
  function automatic logic [SECTOR_W:0] hall_to_sector(input logic [2:0] code);
    case (code)
      3'b001:  return {1'b1, 3'd0};
      3'b011:  return {1'b1, 3'd1};
      3'b010:  return {1'b1, 3'd2};
      3'b110:  return {1'b1, 3'd3};
      3'b100:  return {1'b1, 3'd4};
      3'b101:  return {1'b1, 3'd5};
      default: return {1'b0, 3'd0};
    endcase
  endfunction

  // (new_s - old_s) mod 6; 3-bit wraparound keeps the borrow case exact.
  function automatic logic [SECTOR_W-1:0] sector_delta(input logic [SECTOR_W-1:0] new_s,
                                                       input logic [SECTOR_W-1:0] old_s);
    if (new_s >= old_s) begin
      return new_s - old_s;
    end else begin
      return new_s + 3'd6 - old_s;
    end
  endfunction

endpackage

// File: rtl/servo_hall_filter.sv
// Two-flop synchronizer followed by a stability filter; raises a one-cycle
// accept strobe when a code has stayed stable FILTER_LEN cycles and is new.
module servo_hall_filter #(
  parameter int FILTER_LEN = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] hall,
  output logic [2:0] code,
  output logic       accept
);

  localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam logic [CW-1:0] FMAX = CW'(FILTER_LEN - 1);

  logic [2:0]    sync1;
  logic [2:0]    sync2;
  logic [2:0]    cand;
  logic [2:0]    acc;
  logic [CW-1:0] fcnt;

  // Accept is combinational so the top can register the decode on the same edge.
  always_comb begin
    code   = cand;
    accept = (sync2 == cand) && (fcnt == FMAX) && (cand != acc);
  end

  // Synchronizer, candidate tracking and saturating stability counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 3'b000;
      sync2 <= 3'b000;
      cand  <= 3'b000;
      acc   <= 3'b000;
      fcnt  <= {CW{1'b0}};
    end else begin
      sync1 <= hall;
      sync2 <= sync1;
      if (sync2 != cand) begin
        cand <= sync2;
        fcnt <= {CW{1'b0}};
      end else if (accept) begin
        acc <= cand;
      end else if (fcnt != FMAX) begin
        fcnt <= fcnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/servo_hall_decoder.sv
// Turns raw Hall inputs into filtered sector, direction, step strobe,
// step period, stall indication and sticky fault flags.
module servo_hall_decoder
  import servo_hall_pkg::*;
#(
  parameter int FILTER_LEN = 4,
  parameter int PERIOD_W   = 24
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [2:0]          hall,
  input  logic                fault_clr,
  output logic [SECTOR_W-1:0] sector,
  output logic                sector_valid,
  output logic                dir,
  output logic                step,
  output logic [PERIOD_W-1:0] period,
  output logic                period_valid,
  output logic                stalled,
  output logic [1:0]          fault
);

  localparam logic [PERIOD_W-1:0] PMAX = {PERIOD_W{1'b1}};

  logic [2:0]          code;
  logic                accept;
  logic [SECTOR_W:0]   dec;
  logic [SECTOR_W-1:0] dec_sector;
  logic                dec_valid;
  logic [SECTOR_W-1:0] delta;
  logic                ev_invalid;
  logic                ev_first;
  logic                ev_fwd;
  logic                ev_rev;
  logic                ev_step;
  logic                ev_skip;
  logic                stall_hit;
  logic [1:0]          fault_nxt;
  logic [PERIOD_W-1:0] pcnt;
  logic                chain;

  servo_hall_filter #(.FILTER_LEN(FILTER_LEN)) u_filter (
    .clk    (clk),
    .rst    (rst),
    .hall   (hall),
    .code   (code),
    .accept (accept)
  );

  // Classify the accepted code against the currently held sector.
  always_comb begin
    dec        = hall_to_sector(code);
    dec_valid  = dec[SECTOR_W];
    dec_sector = dec[SECTOR_W-1:0];
    delta      = sector_delta(dec_sector, sector);
    ev_invalid = accept && !dec_valid;
    ev_first   = accept && dec_valid && !sector_valid;
    ev_fwd     = accept && dec_valid && sector_valid && (delta == 3'd1);
    ev_rev     = accept && dec_valid && sector_valid && (delta == 3'd5);
    ev_step    = ev_fwd || ev_rev;
    ev_skip    = accept && dec_valid && sector_valid && !ev_step;
    stall_hit  = !ev_step && !ev_skip && (pcnt == (PMAX - PERIOD_W'(1)));
    // A new fault wins over a simultaneous clear.
    fault_nxt[FAULT_INVALID] = ev_invalid | (fault[FAULT_INVALID] & ~fault_clr);
    fault_nxt[FAULT_SKIP]    = ev_skip    | (fault[FAULT_SKIP]    & ~fault_clr);
  end

  // Sector/direction state, period measurement, stall and fault registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      sector       <= 3'd0;
      sector_valid <= 1'b0;
      dir          <= 1'b0;
      step         <= 1'b0;
      period       <= {PERIOD_W{1'b0}};
      period_valid <= 1'b0;
      stalled      <= 1'b1;
      fault        <= 2'b00;
      pcnt         <= {PERIOD_W{1'b0}};
      chain        <= 1'b0;
    end else begin
      step  <= ev_step;
      fault <= fault_nxt;

      if (ev_invalid) begin
        sector_valid <= 1'b0;
        period_valid <= 1'b0;
        chain        <= 1'b0;
      end else if (ev_first) begin
        sector       <= dec_sector;
        sector_valid <= 1'b1;
      end else if (ev_skip) begin
        sector       <= dec_sector;
        period_valid <= 1'b0;
        chain        <= 1'b0;
      end else if (ev_step) begin
        sector  <= dec_sector;
        dir     <= ev_fwd;
        chain   <= 1'b1;
        stalled <= 1'b0;
        if (chain && (ev_fwd == dir)) begin
          period       <= pcnt + PERIOD_W'(1);
          period_valid <= 1'b1;
        end else begin
          period_valid <= 1'b0;
        end
      end

      // A saturated count cannot yield a true period, so the chain restarts.
      if (stall_hit) begin
        stalled      <= 1'b1;
        period_valid <= 1'b0;
        chain        <= 1'b0;
      end

      if (ev_step || ev_skip) begin
        pcnt <= {PERIOD_W{1'b0}};
      end else if (pcnt != PMAX) begin
        pcnt <= pcnt + PERIOD_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_servo_hall_decoder.sv
// Scoreboard bench: every expected step is queued when its Hall change is
// driven and compared when the DUT pulses `step`.
module tb_servo_hall_decoder;

  localparam int FL = 4;
  localparam int PW = 8;

  typedef struct packed {
    logic [2:0]    sector;
    logic          dir;
    logic          pv;
    logic [PW-1:0] period;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic [2:0]    hall;
  logic          fault_clr;
  logic [2:0]    sector;
  logic          sector_valid;
  logic          dir;
  logic          step;
  logic [PW-1:0] period;
  logic          period_valid;
  logic          stalled;
  logic [1:0]    fault;

  int   checks   = 0;
  int   failures = 0;
  exp_t exp_q[$];

  servo_hall_decoder #(.FILTER_LEN(FL), .PERIOD_W(PW)) dut (
    .clk          (clk),
    .rst          (rst),
    .hall         (hall),
    .fault_clr    (fault_clr),
    .sector       (sector),
    .sector_valid (sector_valid),
    .dir          (dir),
    .step         (step),
    .period       (period),
    .period_valid (period_valid),
    .stalled      (stalled),
    .fault        (fault)
  );

  always #5 clk = ~clk;

  // Advance n cycles, sampling on negedges and consuming the scoreboard on each step.
  task automatic tick(input int n);
    exp_t e;
    exp_t got;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (step === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_step got sector=%0d dir=%0d required no step", sector, dir);
        end else begin
          e   = exp_q.pop_front();
          got = '{sector, dir, period_valid, period};
          if (got !== e || stalled !== 1'b0) begin
            failures++;
            $display("FAIL step_scoreboard got sec=%0d dir=%0d pv=%0d per=%0d stalled=%0d required sec=%0d dir=%0d pv=%0d per=%0d stalled=0",
                     sector, dir, period_valid, period, stalled, e.sector, e.dir, e.pv, e.period);
          end
        end
      end
    end
  endtask

  task automatic drive(input logic [2:0] c, input int gap);
    hall = c;
    tick(gap);
  endtask

  task automatic test_reset();
    checks++;
    if ({sector, sector_valid, dir, step, period, period_valid, stalled, fault} !==
        {3'd0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b1, 2'b00}) begin
      failures++;
      $display("FAIL reset_values got sec=%0d sv=%0d dir=%0d step=%0d per=%0d pv=%0d stl=%0d flt=%b",
               sector, sector_valid, dir, step, period, period_valid, stalled, fault);
    end
    rst = 1'b0;
    tick(6);
    checks++;
    if (sector_valid !== 1'b0) begin
      failures++;
      $display("FAIL early_accept got sv=%0d required 0", sector_valid);
    end
    tick(1);
    checks++;
    if ({sector, sector_valid, step, stalled} !== {3'd0, 1'b1, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL first_accept got sec=%0d sv=%0d step=%0d stl=%0d required 0 1 0 1",
               sector, sector_valid, step, stalled);
    end
  endtask

  task automatic test_forward();
    logic [2:0] codes [6];
    codes = '{3'b011, 3'b010, 3'b110, 3'b100, 3'b101, 3'b001};
    for (int i = 0; i < 6; i++) begin
      exp_q.push_back('{3'((i + 1) % 6), 1'b1, (i > 0), (i > 0) ? 8'd100 : 8'd0});
      drive(codes[i], 100);
    end
    checks++;
    if ({sector, dir, stalled, period_valid} !== {3'd0, 1'b1, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL forward_end got sec=%0d dir=%0d stl=%0d pv=%0d required 0 1 0 1",
               sector, dir, stalled, period_valid);
    end
  endtask

  task automatic test_reverse();
    exp_q.push_back('{3'd1, 1'b1, 1'b1, 8'd100});
    drive(3'b011, 100);
    exp_q.push_back('{3'd0, 1'b0, 1'b0, 8'd100});
    drive(3'b001, 100);
    exp_q.push_back('{3'd5, 1'b0, 1'b1, 8'd100});
    drive(3'b101, 100);
    checks++;
    if (dir !== 1'b0) begin
      failures++;
      $display("FAIL reverse_dir got %0d required 0", dir);
    end
  endtask

  task automatic test_glitch();
    hall = 3'b100;
    tick(FL - 1);
    hall = 3'b101;
    tick(20);
    checks++;
    if (sector !== 3'd5) begin
      failures++;
      $display("FAIL glitch_rejected got sector=%0d required 5", sector);
    end
    exp_q.push_back('{3'd4, 1'b0, 1'b1, 8'd123});
    drive(3'b100, 20);
    checks++;
    if (sector !== 3'd4) begin
      failures++;
      $display("FAIL glitch_then_held got sector=%0d required 4", sector);
    end
  endtask

  task automatic test_skip_invalid();
    exp_q.push_back('{3'd5, 1'b1, 1'b0, 8'd123});
    drive(3'b101, 50);
    exp_q.push_back('{3'd0, 1'b1, 1'b1, 8'd50});
    drive(3'b001, 20);
    drive(3'b010, 20);
    checks++;
    if ({fault, sector, sector_valid, period_valid, dir} !== {2'b10, 3'd2, 1'b1, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL skip got flt=%b sec=%0d sv=%0d pv=%0d dir=%0d required 10 2 1 0 1",
               fault, sector, sector_valid, period_valid, dir);
    end
    drive(3'b111, 20);
    checks++;
    if ({fault, sector, sector_valid} !== {2'b11, 3'd2, 1'b0}) begin
      failures++;
      $display("FAIL invalid got flt=%b sec=%0d sv=%0d required 11 2 0", fault, sector, sector_valid);
    end
    fault_clr = 1'b1;
    tick(1);
    fault_clr = 1'b0;
    checks++;
    if (fault !== 2'b00) begin
      failures++;
      $display("FAIL fault_clr got %b required 00", fault);
    end
    drive(3'b001, 20);
    checks++;
    if ({sector, sector_valid, fault} !== {3'd0, 1'b1, 2'b00}) begin
      failures++;
      $display("FAIL reacquire got sec=%0d sv=%0d flt=%b required 0 1 00", sector, sector_valid, fault);
    end
  endtask

  task automatic test_stall();
    exp_q.push_back('{3'd1, 1'b1, 1'b0, 8'd50});
    drive(3'b011, 30);
    exp_q.push_back('{3'd2, 1'b1, 1'b1, 8'd30});
    drive(3'b010, 261);
    checks++;
    if (stalled !== 1'b0 || period_valid !== 1'b1) begin
      failures++;
      $display("FAIL stall_early got stl=%0d pv=%0d required 0 1", stalled, period_valid);
    end
    tick(1);
    checks++;
    if (stalled !== 1'b1 || period_valid !== 1'b0) begin
      failures++;
      $display("FAIL stall got stl=%0d pv=%0d required 1 0", stalled, period_valid);
    end
  endtask

  task automatic test_reset_mid();
    hall = 3'b110;
    tick(3);
    rst = 1'b1;
    tick(1);
    checks++;
    if ({sector, sector_valid, dir, step, period, period_valid, stalled, fault} !==
        {3'd0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b1, 2'b00}) begin
      failures++;
      $display("FAIL mid_reset got sec=%0d sv=%0d dir=%0d step=%0d per=%0d pv=%0d stl=%0d flt=%b",
               sector, sector_valid, dir, step, period, period_valid, stalled, fault);
    end
    rst = 1'b0;
    tick(6);
    checks++;
    if (sector_valid !== 1'b0) begin
      failures++;
      $display("FAIL post_reset_latency got sv=%0d required 0", sector_valid);
    end
    tick(1);
    checks++;
    if ({sector, sector_valid} !== {3'd3, 1'b1}) begin
      failures++;
      $display("FAIL post_reset_accept got sec=%0d sv=%0d required 3 1", sector, sector_valid);
    end
  endtask

  initial begin
    rst       = 1'b1;
    hall      = 3'b001;
    fault_clr = 1'b0;
    tick(3);
    test_reset();
    test_forward();
    test_reverse();
    test_glitch();
    test_skip_invalid();
    test_stall();
    test_reset_mid();
    tick(10);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL missing_steps got %0d pending required 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
